// File: rtl/tf_exp_gen.sv
// Twiddle-exponent sequencer: issues eight ROM exponents per cycle for a full FFT sweep.
// Latency: EXP*/EXP_* registered from START edge; TF_* tags trail EXP_* by exactly 1 cycle.
// Backpressure: HOLD freezes s/k and all EXP_* outputs; TF_* keep tracking (stable ROM data).
//
// Ports:
//   CLK, RST (async, active-high)   clock / reset
//   START                           sweep launch pulse, honoured only in IDLE (beats HOLD)
//   HOLD                            stall in RUN
//   EXP0..EXP7   [LOG_N-1:0]        ROM read addresses for lanes 0..7
//   EXP_VALID/EXP_STAGE/EXP_LAST    request tags (same cycle as EXP*)
//   TF_VALID/TF_STAGE/TF_LAST       request tags delayed 1 cycle, aligned with ROM data
//   BUSY                            high in RUN
//   DONE                            one-cycle pulse after the final group is consumed
// Build option: define TF_EXP_GEN_DIT_EN for DIT exponent ordering (default is DIF).
module tf_exp_gen #(
  parameter int LOG_N = 12,
  parameter int LANES = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             HOLD,
  output logic [LOG_N-1:0] EXP0,
  output logic [LOG_N-1:0] EXP1,
  output logic [LOG_N-1:0] EXP2,
  output logic [LOG_N-1:0] EXP3,
  output logic [LOG_N-1:0] EXP4,
  output logic [LOG_N-1:0] EXP5,
  output logic [LOG_N-1:0] EXP6,
  output logic [LOG_N-1:0] EXP7,
  output logic             EXP_VALID,
  output logic [3:0]       EXP_STAGE,
  output logic             EXP_LAST,
  output logic             TF_VALID,
  output logic [3:0]       TF_STAGE,
  output logic             TF_LAST,
  output logic             BUSY,
  output logic             DONE
);

  localparam int N  = 1 << LOG_N;
  // N/16 groups per stage; keep at least one bit of k for the LOG_N=4 corner
  localparam int KW = (LOG_N > 4) ? (LOG_N - 4) : 1;
  localparam logic [KW-1:0]    KMAX      = KW'(N / 16 - 1);
  localparam logic [3:0]       SMAX      = 4'(LOG_N - 1);
  localparam logic [LOG_N-1:0] HALF_MASK = LOG_N'(N / 2 - 1);

  generate
    if (LANES != 8) begin : g_lanes_chk
      $error("tf_exp_gen: LANES must be 8");
    end
    if (LOG_N < 4 || LOG_N > 12) begin : g_logn_chk
      $error("tf_exp_gen: LOG_N must be in 4..12");
    end
  endgenerate

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           state;
  logic [3:0]       s;
  logic [KW-1:0]    k;
  logic [LOG_N-1:0] exp_q  [8];

  logic [3:0]       ld_s;
  logic [KW-1:0]    ld_k;
  logic [LOG_N-1:0] ld_exp [8];
  logic             sweep_end;

  // Spans are powers of two, so "j mod span" is a mask of j's low bits.
  function automatic logic [LOG_N-1:0] exp_of(input logic [3:0] st,
                                               input logic [KW-1:0] kk,
                                               input logic [2:0] lane);
    logic [LOG_N-1:0] j;
    j = (LOG_N'(kk) << 3) | LOG_N'(lane);
`ifdef TF_EXP_GEN_DIT_EN
    // span = 1<<st: keep st low bits, then scale up to the N/2 exponent range
    return (j & ((LOG_N'(1) << st) - LOG_N'(1))) << (LOG_N - 1 - int'(st));
`else
    // span = N>>(st+1): mask is (N/2-1)>>st, result scaled by 1<<st
    return (j & (HALF_MASK >> st)) << st;
`endif
  endfunction

  // Next request coordinates: (0,0) when launching from IDLE, else advance k/s.
  always_comb begin
    ld_s = s;
    ld_k = k + KW'(1);
    if (state != ST_RUN) begin
      ld_s = '0;
      ld_k = '0;
    end else if (k == KMAX) begin
      ld_s = s + 4'd1;
      ld_k = '0;
    end
    for (int l = 0; l < 8; l++) begin
      ld_exp[l] = exp_of(ld_s, ld_k, 3'(l));
    end
  end

  assign sweep_end = (s == SMAX) && (k == KMAX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      s         <= '0;
      k         <= '0;
      for (int l = 0; l < 8; l++) exp_q[l] <= '0;
      EXP_VALID <= 1'b0;
      EXP_STAGE <= '0;
      EXP_LAST  <= 1'b0;
      TF_VALID  <= 1'b0;
      TF_STAGE  <= '0;
      TF_LAST   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      // Tags follow the ROM's one-cycle read every cycle, stalled or not
      TF_VALID <= EXP_VALID;
      TF_STAGE <= EXP_STAGE;
      TF_LAST  <= EXP_LAST;
      DONE     <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (START) begin
            state     <= ST_RUN;
            s         <= ld_s;
            k         <= ld_k;
            for (int l = 0; l < 8; l++) exp_q[l] <= ld_exp[l];
            EXP_VALID <= 1'b1;
            EXP_STAGE <= ld_s;
            EXP_LAST  <= (ld_k == KMAX);
            BUSY      <= 1'b1;
          end
        end

        ST_RUN: begin
          if (!HOLD) begin
            if (sweep_end) begin
              state     <= ST_DONE;
              s         <= '0;
              k         <= '0;
              for (int l = 0; l < 8; l++) exp_q[l] <= '0;
              EXP_VALID <= 1'b0;
              EXP_STAGE <= '0;
              EXP_LAST  <= 1'b0;
              BUSY      <= 1'b0;
              DONE      <= 1'b1;
            end else begin
              s         <= ld_s;
              k         <= ld_k;
              for (int l = 0; l < 8; l++) exp_q[l] <= ld_exp[l];
              EXP_STAGE <= ld_s;
              EXP_LAST  <= (ld_k == KMAX);
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign EXP0 = exp_q[0];
  assign EXP1 = exp_q[1];
  assign EXP2 = exp_q[2];
  assign EXP3 = exp_q[3];
  assign EXP4 = exp_q[4];
  assign EXP5 = exp_q[5];
  assign EXP6 = exp_q[6];
  assign EXP7 = exp_q[7];

endmodule

// File: tb/tb_tf_exp_gen.sv
// Bench for tf_exp_gen: full sweeps against a queued reference sequence.
// Covers launch, stage boundaries, HOLD freeze, START-in-RUN, async reset mid-sweep.
// Expected values come from an arithmetic model plus a table of literal groups.
module tb_tf_exp_gen;
  localparam int LOG_N = 12;
  localparam int N     = 1 << LOG_N;
  localparam int GRP   = N / 16;

  logic CLK = 1'b0;
  logic RST, START, HOLD;
  logic [LOG_N-1:0] EXP0, EXP1, EXP2, EXP3, EXP4, EXP5, EXP6, EXP7;
  logic EXP_VALID, EXP_LAST, TF_VALID, TF_LAST, BUSY, DONE;
  logic [3:0] EXP_STAGE, TF_STAGE;

  tf_exp_gen #(.LOG_N(LOG_N), .LANES(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .HOLD(HOLD),
    .EXP0(EXP0), .EXP1(EXP1), .EXP2(EXP2), .EXP3(EXP3),
    .EXP4(EXP4), .EXP5(EXP5), .EXP6(EXP6), .EXP7(EXP7),
    .EXP_VALID(EXP_VALID), .EXP_STAGE(EXP_STAGE), .EXP_LAST(EXP_LAST),
    .TF_VALID(TF_VALID), .TF_STAGE(TF_STAGE), .TF_LAST(TF_LAST),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef int lane_arr_t [8];
  typedef struct { int s; int k; logic [127:0] v; } ent_t;

  ent_t         sb[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [127:0] last_obs;
  bit           prev_vld;
  logic [5:0]   prev_tf;
  int           valid_cnt, done_cnt, exp_cnt_g;
  int           cur_s, cur_k;
  bit           fresh;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic int model_exp(input int s, input int k, input int l);
    int j, span;
    j = 8 * k + l;
`ifdef TF_EXP_GEN_DIT_EN
    span = 1 << s;
    return (j % span) << (LOG_N - 1 - s);
`else
    span = N >> (s + 1);
    return (j % span) << s;
`endif
  endfunction

  function automatic logic [127:0] pack(input lane_arr_t e, input int s, input bit last);
    logic [127:0] v;
    v = '0;
    for (int l = 0; l < 8; l++) v[12*l +: 12] = 12'(e[l]);
    v[99:96] = 4'(s);
    v[100]   = last;
    return v;
  endfunction

  function automatic logic [127:0] obs_pack();
    return {27'b0, EXP_LAST, EXP_STAGE, EXP7, EXP6, EXP5, EXP4, EXP3, EXP2, EXP1, EXP0};
  endfunction

  function automatic logic [127:0] outs_all();
    logic [127:0] v;
    v = obs_pack();
    v[127:120] = {EXP_VALID, TF_VALID, TF_LAST, BUSY, DONE, 3'b0};
    v[119:116] = TF_STAGE;
    return v;
  endfunction

  // Literal groups worked out by hand for selected (stage, group) points.
  function automatic bit directed(input int s, input int k, output logic [127:0] v);
    lane_arr_t e;
    bit hit;
    hit = 1'b1;
    e   = '{0, 0, 0, 0, 0, 0, 0, 0};
`ifdef TF_EXP_GEN_DIT_EN
    if (s == 0 && k == 0)       e = '{0, 0, 0, 0, 0, 0, 0, 0};
    else if (s == 11 && k == 0) e = '{0, 1, 2, 3, 4, 5, 6, 7};
    else if (s == 10 && k == 0) e = '{0, 2, 4, 6, 8, 10, 12, 14};
    else hit = 1'b0;
`else
    if (s == 0 && k == 0)        e = '{0, 1, 2, 3, 4, 5, 6, 7};
    else if (s == 0 && k == 1)   e = '{8, 9, 10, 11, 12, 13, 14, 15};
    else if (s == 0 && k == 255) e = '{2040, 2041, 2042, 2043, 2044, 2045, 2046, 2047};
    else if (s == 1 && k == 0)   e = '{0, 2, 4, 6, 8, 10, 12, 14};
    else if (s == 9 && k == 0)   e = '{0, 512, 1024, 1536, 0, 512, 1024, 1536};
    else if (s == 10 && k == 0)  e = '{0, 1024, 0, 1024, 0, 1024, 0, 1024};
    else if (s == 11 && k == 0)  e = '{0, 0, 0, 0, 0, 0, 0, 0};
    else hit = 1'b0;
`endif
    v = pack(e, s, k == GRP - 1);
    return hit;
  endfunction

  task automatic push_sweep();
    lane_arr_t e;
    ent_t      en;
    for (int s = 0; s < LOG_N; s++) begin
      for (int k = 0; k < GRP; k++) begin
        for (int l = 0; l < 8; l++) e[l] = model_exp(s, k, l);
        en.s = s;
        en.k = k;
        en.v = pack(e, s, k == GRP - 1);
        sb.push_back(en);
      end
    end
  endtask

  // Called at each negedge, before inputs for the next posedge change.
  task automatic monitor();
    logic [127:0] obs, dv;
    ent_t         e;
    obs   = obs_pack();
    fresh = 1'b0;
    chk("tf_pipe", 128'({TF_VALID, TF_STAGE, TF_LAST}), 128'(prev_tf));
    prev_tf = {EXP_VALID, EXP_STAGE, EXP_LAST};
    if (EXP_VALID) begin
      valid_cnt++;
      if (prev_vld && HOLD) begin
        chk("hold_frozen", obs, last_obs);
      end else if (sb.size() == 0) begin
        chk("unexpected_valid", 128'(1), 128'(0));
      end else begin
        e = sb.pop_front();
        chk($sformatf("exp_s%0d_k%0d", e.s, e.k), obs, e.v);
        if (directed(e.s, e.k, dv)) chk($sformatf("table_s%0d_k%0d", e.s, e.k), obs, dv);
        cur_s = e.s;
        cur_k = e.k;
        fresh = 1'b1;
      end
      if (valid_cnt == 1) chk("busy_run", 128'(BUSY), 128'(1));
    end
    if (DONE) begin
      done_cnt++;
      chk("done_tf_last", 128'(TF_LAST), 128'(1));
      chk("done_busy", 128'(BUSY), 128'(0));
      chk("done_exp_valid", 128'(EXP_VALID), 128'(0));
      chk("done_valid_count", 128'(valid_cnt), 128'(exp_cnt_g));
    end
    last_obs = obs;
    prev_vld = EXP_VALID;
  endtask

  // mode 0: plain sweep; 1: HOLD at s3/k17 plus START pulses in RUN; 2: RST at s6.
  task automatic run_sweep(input int mode, input int exp_cnt);
    int cyc, hold_left;
    bit hold_done, stop;
    cyc = 0; hold_left = 0; hold_done = 1'b0; stop = 1'b0;
    valid_cnt = 0; done_cnt = 0; exp_cnt_g = exp_cnt;
    push_sweep();
    START = 1'b1;
    HOLD  = (mode == 0);  // START must win over HOLD in IDLE
    while (!stop && cyc < 5000) begin
      @(negedge CLK);
      monitor();
      cyc++;
      START = 1'b0;
      if (cyc == 1) HOLD = 1'b0;
      if (mode == 1) begin
        if (hold_left > 0) begin
          hold_left--;
          HOLD = (hold_left > 0);
        end
        if (fresh && cur_s == 3 && cur_k == 17 && !hold_done) begin
          hold_done = 1'b1;
          hold_left = 5;
          HOLD      = 1'b1;
        end
        if (fresh && cur_k == 100 && (cur_s == 2 || cur_s == 7)) START = 1'b1;
      end
      if (mode == 2 && fresh && cur_s == 6 && cur_k == 0) begin
        #2 RST = 1'b1;
        #1 chk("rst_async_zero", outs_all(), 128'(0));
        @(negedge CLK);
        chk("rst_held_zero", outs_all(), 128'(0));
        RST = 1'b0;
        sb.delete();
        prev_vld = 1'b0;
        prev_tf  = '0;
        stop     = 1'b1;
      end
      if (DONE) stop = 1'b1;
    end
    HOLD  = 1'b0;
    START = 1'b0;
    if (!stop) chk("sweep_timeout", 128'(cyc), 128'(0));
    repeat (3) begin
      @(negedge CLK);
      monitor();
    end
    chk("done_pulses", 128'(done_cnt), 128'((mode == 2) ? 0 : 1));
    chk("sb_drained", 128'(sb.size()), 128'(0));
    chk("idle_busy", 128'(BUSY), 128'(0));
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; HOLD = 1'b0;
    prev_vld = 1'b0; prev_tf = '0; last_obs = '0;
    valid_cnt = 0; done_cnt = 0; exp_cnt_g = 0; cur_s = 0; cur_k = 0; fresh = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset_state", outs_all(), 128'(0));
    RST = 1'b0;
    @(negedge CLK);
    monitor();
    run_sweep(0, LOG_N * GRP);
    run_sweep(1, LOG_N * GRP + 5);
    run_sweep(2, 0);
    run_sweep(0, LOG_N * GRP);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tf_exp_gen.md
Name: tf_exp_gen

Overview:
- Twiddle-exponent sequencer that initiates all twiddle lookups for a full FFT sweep.
- Each cycle it drives eight 12-bit exponents into the 8-port twiddle ROM bank. The ROM has a 1-cycle registered read.
- It also produces side-band valid/stage/last tags, delayed one cycle so they align with the returned TF0..TF7 words for the butterfly datapath.
- Default ordering is radix-2 DIF; stage sweeps run 0..LOG_N-1 with 8 butterflies per cycle.

Parameters:
- LOG_N, 12, log2 of FFT size N. Exponent width = LOG_N. Legal range 4..12.
- LANES, 8, butterflies per cycle. Fixed at 8; any other value is a synthesis error.

Ports:
- CLK  in  1  clock
- RST  in  1  reset; asynchronous, active-high
- START  in  1  sweep launch pulse; honoured only in IDLE
- HOLD  in  1  stall; freezes all counters and EXP outputs
- EXP0..EXP7  out  LOG_N each  exponents for lanes 0..7; connect to the ROM ADDR ports
- EXP_VALID  out  1  EXP0..7 hold a live request
- EXP_STAGE  out  4  stage index of the current request
- EXP_LAST  out  1  current request is the final group of its stage
- TF_VALID  out  1  EXP_VALID delayed 1 cycle; qualifies ROM TF0..TF7
- TF_STAGE  out  4  EXP_STAGE delayed 1 cycle
- TF_LAST  out  1  EXP_LAST delayed 1 cycle
- BUSY  out  1  high in RUN
- DONE  out  1  one-cycle pulse at sweep end

Behaviour:
- Reset values: all outputs 0; state IDLE; stage counter s=0; group counter k=0.
- States:
  - IDLE: START=1 at a posedge moves to RUN and loads s=0, k=0. Outputs are registered, so EXP_VALID=1 with stage-0 group-0 exponents from that edge.
  - RUN, HOLD=0 at an edge: advance k. When k=N/16-1, wrap k to 0 and increment s. When s=LOG_N-1 and k=N/16-1, go to DONE.
  - RUN, HOLD=1: s, k, EXP*, EXP_VALID, EXP_STAGE and EXP_LAST all stay unchanged.
  - DONE: lasts one cycle. DONE=1, BUSY=0, EXP_VALID=0, then return to IDLE. HOLD is ignored in DONE.
- START is ignored in RUN and DONE. START and HOLD asserted together in IDLE: START wins.
- Exponent law (DIF): lane l, butterfly j=8k+l, span=N>>(s+1), EXPl=(j mod span)<<s. The result is always < N/2 and zero-extended to LOG_N bits.
- Spans smaller than 8 occur in the last three stages and need no special case.
  - Example, s=LOG_N-1: span=1, so all lanes output 0.
- EXP_LAST = (k==N/16-1) while EXP_VALID.
- Request count: LOG_N*N/16 EXP_VALID cycles per sweep, excluding hold cycles. That is 3072 for LOG_N=12.
- TF pipeline: TF_VALID, TF_STAGE and TF_LAST are registered copies of EXP_VALID, EXP_STAGE and EXP_LAST every cycle, including hold cycles.
  - During HOLD the addresses are stable, so the ROM output is stable and TF_VALID stays high.
  - The consumer honours HOLD itself.
- Reset mid-sweep: immediate return to IDLE with all outputs 0. No DONE pulse.
- DONE asserts exactly one cycle after the edge that consumed the final group. TF_LAST of the final group coincides with DONE.

Optional Feature:
- Macro: TF_EXP_GEN_DIT_EN.
- When defined: DIT ordering. span=1<<s; EXPl=(j mod span)<<(LOG_N-1-s).
  - Stage 0 gives all zeros; the final stage gives j.
- When undefined: DIF law above.
- Counters, handshake and timing are identical in both builds.

Test Plan:
1. Reset, then a START pulse. Expect:
   - First valid cycle: s=0, EXP0..7=0..7.
   - Next cycle: 8..15.
   - EXP_LAST at k=255, with EXP0..7=2040..2047.
2. Stage-1 first group: 0,2,4,..,14. Stage 9 first group: 0,512,1024,1536,0,512,1024,1536. Stage 10: 0,1024 alternating. Stage 11: all 0.
3. Full sweep, no HOLD:
   - exactly 3072 EXP_VALID cycles;
   - DONE is a single pulse, coincident with the final TF_LAST;
   - BUSY falls with DONE;
   - TF_VALID lags EXP_VALID by exactly 1 cycle.
4. HOLD for 5 cycles at s=3, k=17:
   - EXP*, EXP_LAST and the counters are frozen, and TF_VALID stays 1;
   - after release, the sequence resumes at k=18 with no skip or duplicate;
   - total EXP_VALID cycles = 3077.
5. START pulses during RUN are ignored (sweep length unchanged). Assert RST at s=6: all outputs go to 0 asynchronously and there is no DONE. A new START then restarts from s=0, k=0.
6. Build with TF_EXP_GEN_DIT_EN: stage 0 gives all 0; stage 11 group 0 gives 0..7; stage 10 group 0 gives 0,2,..,14.
